// File: rtl/sha256_round_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_round_scheduler
//  Brief    : Sequences the SHA-256 round datapath over multi-block messages,
//             chaining each block's result into the next block's prev_hash.
//  Revision : 1.0
// ============================================================================
module sha256_round_scheduler #(
   parameter int           WK_LENGTH     = 64,
   parameter int           GAP_CYCLES    = 4,
   parameter int           DRAIN_TIMEOUT = 8,
   parameter logic [255:0] IV            = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         blk_valid,
   input  logic                         blk_last,
   output logic                         blk_ready,
   output logic                         rnd_enable,
   output logic [$clog2(WK_LENGTH)-1:0] rnd_index,
   output logic                         rnd_last,
   output logic [255:0]                 prev_hash,
   input  logic                         hash_done,
   input  logic [255:0]                 updated_hash,
   output logic                         digest_valid,
   output logic [255:0]                 digest,
   input  logic                         digest_ready,
   output logic                         busy,
   output logic [15:0]                  block_count,
   output logic                         error
);

   localparam int                     c_IDX_W       = $clog2(WK_LENGTH);
   localparam logic [c_IDX_W-1:0]     c_IDX_LAST    = c_IDX_W'(WK_LENGTH - 1);
   localparam logic [c_IDX_W-1:0]     c_IDX_PENULT  = c_IDX_W'(WK_LENGTH - 2);
   localparam logic [3:0]             c_GAP_LAST    = 4'(GAP_CYCLES - 1);
   localparam logic [7:0]             c_DRAIN_LAST  = 8'(DRAIN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_BLK = 3'd1,
      S_GAP      = 3'd2,
      S_ROUNDS   = 3'd3,
      S_DRAIN    = 3'd4,
      S_OUT      = 3'd5
   } state_t;

   state_t               r_state;
   logic                 r_last_q;
   logic [3:0]           r_gap_cnt;
   logic [7:0]           r_drain_cnt;
   logic                 r_blk_ready;
   logic                 r_rnd_enable;
   logic [c_IDX_W-1:0]   r_rnd_index;
   logic                 r_rnd_last;
   logic [255:0]         r_prev_hash;
   logic                 r_digest_valid;
   logic [255:0]         r_digest;
   logic [15:0]          r_block_count;
   logic                 r_error;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_last_q       <= 1'b0;
         r_gap_cnt      <= 4'd0;
         r_drain_cnt    <= 8'd0;
         r_blk_ready    <= 1'b0;
         r_rnd_enable   <= 1'b0;
         r_rnd_index    <= '0;
         r_rnd_last     <= 1'b0;
         r_prev_hash    <= IV;
         r_digest_valid <= 1'b0;
         r_digest       <= 256'd0;
         r_block_count  <= 16'd0;
         r_error        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_prev_hash   <= IV;
                  r_block_count <= 16'd0;
                  r_error       <= 1'b0;
                  r_blk_ready   <= 1'b1;
                  r_state       <= S_WAIT_BLK;
               end
            end
            S_WAIT_BLK: begin
               if (blk_valid && r_blk_ready) begin
                  r_last_q    <= blk_last;
                  r_gap_cnt   <= 4'd0;
                  r_blk_ready <= 1'b0;
                  r_state     <= S_GAP;
               end
            end
            S_GAP: begin
               // Enable stays low so the datapath reloads prev_hash before round 0.
               if (r_gap_cnt == c_GAP_LAST) begin
                  r_rnd_enable <= 1'b1;
                  r_rnd_index  <= '0;
                  r_rnd_last   <= (WK_LENGTH == 1);
                  r_state      <= S_ROUNDS;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 4'd1;
               end
            end
            S_ROUNDS: begin
               if (r_rnd_index == c_IDX_LAST) begin
                  r_drain_cnt <= 8'd0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_rnd_index <= r_rnd_index + 1'b1;
                  r_rnd_last  <= (r_rnd_index == c_IDX_PENULT);
               end
            end
            S_DRAIN: begin
               // hash_done wins over a coincident timeout expiry.
               if (hash_done) begin
                  r_prev_hash  <= updated_hash;
                  r_rnd_enable <= 1'b0;
                  r_rnd_last   <= 1'b0;
                  r_rnd_index  <= '0;
                  if (r_block_count != 16'hFFFF) begin
                     r_block_count <= r_block_count + 16'd1;
                  end
                  if (r_last_q) begin
                     r_digest       <= updated_hash;
                     r_digest_valid <= 1'b1;
                     r_state        <= S_OUT;
                  end else begin
                     r_blk_ready <= 1'b1;
                     r_state     <= S_WAIT_BLK;
                  end
               end else if (r_drain_cnt == c_DRAIN_LAST) begin
                  r_error      <= 1'b1;
                  r_rnd_enable <= 1'b0;
                  r_rnd_last   <= 1'b0;
                  r_rnd_index  <= '0;
                  r_state      <= S_IDLE;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 8'd1;
               end
            end
            S_OUT: begin
               if (digest_ready) begin
                  r_digest_valid <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign blk_ready    = r_blk_ready;
   assign rnd_enable   = r_rnd_enable;
   assign rnd_index    = r_rnd_index;
   assign rnd_last     = r_rnd_last;
   assign prev_hash    = r_prev_hash;
   assign digest_valid = r_digest_valid;
   assign digest       = r_digest;
   assign busy         = (r_state != S_IDLE);
   assign block_count  = r_block_count;
   assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_round_scheduler
//  Brief    : Directed self-checking bench with a digest scoreboard queue.
//  Revision : 1.0
// ============================================================================
module tb_sha256_round_scheduler;

   localparam logic [255:0] c_IV = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
   localparam logic [255:0] c_D1 = {4{64'h1234_5678_9abc_def0}};
   localparam logic [255:0] c_X1 = {4{64'hdead_beef_0bad_f00d}};
   localparam logic [255:0] c_X2 = {4{64'hcafe_babe_5555_aaaa}};

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         blk_valid;
   logic         blk_last;
   logic         blk_ready;
   logic         rnd_enable;
   logic [5:0]   rnd_index;
   logic         rnd_last;
   logic [255:0] prev_hash;
   logic         hash_done;
   logic [255:0] updated_hash;
   logic         digest_valid;
   logic [255:0] digest;
   logic         digest_ready;
   logic         busy;
   logic [15:0]  block_count;
   logic         error;

   int           n_vec  = 0;
   int           n_fail = 0;
   logic [255:0] exp_q[$];

   sha256_round_scheduler #(
      .WK_LENGTH     (64),
      .GAP_CYCLES    (4),
      .DRAIN_TIMEOUT (8),
      .IV            (c_IV)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .blk_valid    (blk_valid),
      .blk_last     (blk_last),
      .blk_ready    (blk_ready),
      .rnd_enable   (rnd_enable),
      .rnd_index    (rnd_index),
      .rnd_last     (rnd_last),
      .prev_hash    (prev_hash),
      .hash_done    (hash_done),
      .updated_hash (updated_hash),
      .digest_valid (digest_valid),
      .digest       (digest),
      .digest_ready (digest_ready),
      .busy         (busy),
      .block_count  (block_count),
      .error        (error)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One block: handshake, gap, rounds; optionally answer hash_done 3 cycles after rnd_last.
   task automatic run_block(input logic last, input logic [255:0] result,
                            input logic [255:0] exp_prev, input bit respond,
                            input logic [15:0] exp_cnt);
      int k;
      k = 0;
      while (!blk_ready && k < 20) begin
         tick();
         k++;
      end
      chkb("blk_ready_wait", blk_ready, 1'b1);
      blk_valid = 1'b1;
      blk_last  = last;
      tick();
      blk_valid = 1'b0;
      blk_last  = 1'b0;
      chkb("blk_ready_drop", blk_ready, 1'b0);
      for (int g = 0; g < 4; g++) begin
         chkb("gap_rnd_enable", rnd_enable, 1'b0);
         chkv("gap_prev_hash", prev_hash, exp_prev);
         tick();
      end
      for (int i = 0; i < 64; i++) begin
         chkb("rounds_rnd_enable", rnd_enable, 1'b1);
         chkv("rounds_rnd_index", 256'(rnd_index), 256'(i));
         chkb("rounds_rnd_last", rnd_last, logic'(i == 63));
         if (i == 0 || i == 63) chkv("rounds_prev_hash", prev_hash, exp_prev);
         if (i < 63) tick();
      end
      if (respond) begin
         tick();
         chkb("drain_rnd_enable", rnd_enable, 1'b1);
         chkb("drain_rnd_last", rnd_last, 1'b1);
         chkv("drain_rnd_index", 256'(rnd_index), 256'd63);
         tick();
         tick();
         hash_done    = 1'b1;
         updated_hash = result;
         if (last) exp_q.push_back(result);
         tick();
         hash_done    = 1'b0;
         updated_hash = 256'd0;
         chkb("post_done_rnd_enable", rnd_enable, 1'b0);
         chkb("post_done_rnd_last", rnd_last, 1'b0);
         chkv("post_done_prev_hash", prev_hash, result);
         chkv("block_count", 256'(block_count), 256'(exp_cnt));
      end
   endtask

   // Wait for the digest, compare against the scoreboard, hold off for 'hold' cycles.
   task automatic get_digest(input int hold);
      int           k;
      logic [255:0] exp;
      k = 0;
      while (!digest_valid && k < 20) begin
         tick();
         k++;
      end
      chkb("digest_valid", digest_valid, 1'b1);
      if (exp_q.size() == 0) begin
         n_vec++;
         n_fail++;
         $error("FAIL scoreboard_empty: observed digest %h expected none", digest);
         exp = 256'd0;
      end else begin
         exp = exp_q.pop_front();
      end
      chkv("digest", digest, exp);
      for (int h = 0; h < hold; h++) begin
         digest_ready = 1'b0;
         start        = (h == 3);
         tick();
         start = 1'b0;
         chkb("hold_digest_valid", digest_valid, 1'b1);
         chkv("hold_digest", digest, exp);
         chkb("hold_busy", busy, 1'b1);
      end
      digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      chkb("after_accept_valid", digest_valid, 1'b0);
      chkb("after_accept_busy", busy, 1'b0);
   endtask

   initial begin
      int k;
      reset        = 1'b0;
      start        = 1'b0;
      blk_valid    = 1'b0;
      blk_last     = 1'b0;
      hash_done    = 1'b0;
      updated_hash = 256'd0;
      digest_ready = 1'b0;

      // Reset held with random inputs.
      for (int r = 0; r < 4; r++) begin
         start        = 1'($urandom);
         blk_valid    = 1'($urandom);
         blk_last     = 1'($urandom);
         hash_done    = 1'($urandom);
         digest_ready = 1'($urandom);
         updated_hash = {8{$urandom}};
         tick();
      end
      chkv("rst_prev_hash", prev_hash, c_IV);
      chkv("rst_digest", digest, 256'd0);
      chkb("rst_blk_ready", blk_ready, 1'b0);
      chkb("rst_rnd_enable", rnd_enable, 1'b0);
      chkv("rst_rnd_index", 256'(rnd_index), 256'd0);
      chkb("rst_rnd_last", rnd_last, 1'b0);
      chkb("rst_digest_valid", digest_valid, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chkv("rst_block_count", 256'(block_count), 256'd0);
      chkb("rst_error", error, 1'b0);

      start        = 1'b0;
      blk_valid    = 1'b0;
      blk_last     = 1'b0;
      hash_done    = 1'b0;
      digest_ready = 1'b0;
      updated_hash = 256'd0;
      reset        = 1'b1;
      for (int r = 0; r < 3; r++) tick();
      chkb("idle_busy", busy, 1'b0);
      chkb("idle_blk_ready", blk_ready, 1'b0);
      chkv("idle_prev_hash", prev_hash, c_IV);

      // Single block, digest accepted in first OUT cycle.
      start = 1'b1;
      tick();
      start = 1'b0;
      chkb("wait_busy", busy, 1'b1);
      tick();
      run_block(1'b1, c_D1, c_IV, 1'b1, 16'd1);
      get_digest(0);

      // Two chained blocks with digest backpressure and an ignored start in OUT.
      start = 1'b1;
      tick();
      start = 1'b0;
      run_block(1'b0, c_X1, c_IV, 1'b1, 16'd1);
      run_block(1'b1, c_X2, c_X1, 1'b1, 16'd2);
      get_digest(10);

      // Timeout: no hash_done ever arrives.
      start = 1'b1;
      tick();
      start = 1'b0;
      run_block(1'b1, 256'd0, c_IV, 1'b0, 16'd0);
      tick();
      for (int j = 1; j < 8; j++) begin
         tick();
         chkb("drain_error_low", error, 1'b0);
         chkb("drain_busy", busy, 1'b1);
      end
      tick();
      chkb("timeout_error", error, 1'b1);
      chkb("timeout_busy", busy, 1'b0);
      chkb("timeout_rnd_enable", rnd_enable, 1'b0);
      chkv("timeout_digest", digest, c_X2);
      start = 1'b1;
      tick();
      start = 1'b0;
      chkb("start_clears_error", error, 1'b0);
      chkb("start_busy", busy, 1'b1);

      // Reset in the middle of the rounds.
      k = 0;
      while (!blk_ready && k < 20) begin
         tick();
         k++;
      end
      blk_valid = 1'b1;
      blk_last  = 1'b0;
      tick();
      blk_valid = 1'b0;
      for (int g = 0; g < 4; g++) tick();
      for (int i = 0; i < 30; i++) tick();
      chkv("mid_rnd_index", 256'(rnd_index), 256'd30);
      chkb("mid_rnd_enable", rnd_enable, 1'b1);
      #1 reset = 1'b0;
      #1;
      chkb("async_rnd_enable", rnd_enable, 1'b0);
      chkv("async_rnd_index", 256'(rnd_index), 256'd0);
      chkv("async_prev_hash", prev_hash, c_IV);
      chkb("async_busy", busy, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      tick();
      chkb("post_reset_busy", busy, 1'b0);
      chkb("post_reset_rnd_enable", rnd_enable, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
